// File: rtl/uart_cmd_if.sv
// FIFO-side handshake bundle for the UART command controller.
// The controller takes the master view, the RX/TX FIFO pair takes the slave view.
interface uart_cmd_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd_en;
    logic       tx_full;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;

    modport master (
        input  rx_empty, rx_data, tx_full,
        output rx_rd_en, tx_wr_en, tx_wr_data
    );

    modport slave (
        output rx_empty, rx_data, tx_full,
        input  rx_rd_en, tx_wr_en, tx_wr_data
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// Framed command parser over RX/TX byte FIFOs driving a 4 x 8-bit register file.
// Accepts {SYNC, CMD, DATA, CHK} frames and answers each with {RESP, STATUS, DATA, CHK}.
//
// state  | meaning
// IDLE   | hunting for SYNC_BYTE, other bytes dropped
// CMD    | waiting for command byte
// DATA   | waiting for data byte
// CHK    | waiting for checksum byte
// EXEC   | one cycle: decode, update register file, set status
// R_SYNC | pushing RESP_BYTE
// R_STAT | pushing status
// R_DATA | pushing response data
// R_CHK  | pushing response checksum, then back to IDLE
module uart_cmd_controller #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [7:0]  RESP_BYTE      = 8'hAA,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_cmd_if.master  bus,
    output logic [31:0] reg_out,
    output logic [7:0]  err_count,
    output logic        frame_ok,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, CMD, DATA, CHK, EXEC, R_SYNC, R_STAT, R_DATA, R_CHK
    } state_t;

    state_t        state, state_nxt;
    logic          wait_q;
    logic [7:0]    byte_q, sum_q, data_q, stat_q, rdat_q;
    logic [3:0]    op_q;
    logic [1:0]    idx_q;
    logic          chk_ok_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    regs [4];

    logic          rx_phase, frame_phase, pop, timeout, ex_write;
    logic [7:0]    ex_stat, ex_data;

    assign rx_phase    = (state == IDLE) || (state == CMD) || (state == DATA) || (state == CHK);
    assign frame_phase = (state == CMD) || (state == DATA) || (state == CHK);
    // Gated by rst_n so no pop is issued while the FIFO sits in front of a held reset.
    assign pop         = rst_n && rx_phase && !wait_q && !bus.rx_empty;
    assign timeout     = frame_phase && !pop && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    assign bus.rx_rd_en = pop;
    assign busy         = (state != IDLE);
    assign reg_out      = {regs[3], regs[2], regs[1], regs[0]};

    always_comb begin
        state_nxt      = state;
        ex_stat        = 8'h00;
        ex_data        = 8'h00;
        ex_write       = 1'b0;
        frame_ok       = 1'b0;
        bus.tx_wr_en   = 1'b0;
        bus.tx_wr_data = 8'h00;
        case (state)
            IDLE: if (wait_q && byte_q == SYNC_BYTE) state_nxt = CMD;
            CMD:  if (wait_q) state_nxt = DATA;
            DATA: if (wait_q) state_nxt = CHK;
            CHK:  if (wait_q) state_nxt = EXEC;
            EXEC: begin
                if (!chk_ok_q) begin
                    ex_stat = 8'h01;
                end else if (op_q == 4'h1) begin
                    ex_write = 1'b1;
                    ex_data  = data_q;
                end else if (op_q == 4'h2) begin
                    ex_data = regs[idx_q];
                end else begin
                    ex_stat = 8'h02;
                end
                frame_ok  = (ex_stat == 8'h00);
                state_nxt = R_SYNC;
            end
            R_SYNC: begin
                bus.tx_wr_data = RESP_BYTE;
                bus.tx_wr_en   = !bus.tx_full;
                if (!bus.tx_full) state_nxt = R_STAT;
            end
            R_STAT: begin
                bus.tx_wr_data = stat_q;
                bus.tx_wr_en   = !bus.tx_full;
                if (!bus.tx_full) state_nxt = R_DATA;
            end
            R_DATA: begin
                bus.tx_wr_data = rdat_q;
                bus.tx_wr_en   = !bus.tx_full;
                if (!bus.tx_full) state_nxt = R_CHK;
            end
            R_CHK: begin
                bus.tx_wr_data = stat_q + rdat_q;
                bus.tx_wr_en   = !bus.tx_full;
                if (!bus.tx_full) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_q    <= 1'b0;
            byte_q    <= 8'h00;
            sum_q     <= 8'h00;
            data_q    <= 8'h00;
            stat_q    <= 8'h00;
            rdat_q    <= 8'h00;
            op_q      <= 4'h0;
            idx_q     <= 2'd0;
            chk_ok_q  <= 1'b0;
            tmo_q     <= '0;
            err_count <= 8'h00;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            state  <= state_nxt;
            wait_q <= pop;
            if (pop) byte_q <= bus.rx_data;
            // Bytes are folded in during the wait cycle, once the popped value is in byte_q.
            if (state == CMD && wait_q) begin
                op_q  <= byte_q[7:4];
                idx_q <= byte_q[1:0];
                sum_q <= byte_q;
            end
            if (state == DATA && wait_q) begin
                data_q <= byte_q;
                sum_q  <= sum_q + byte_q;
            end
            if (state == CHK && wait_q) chk_ok_q <= (byte_q == sum_q);
            if (pop || !frame_phase || timeout) tmo_q <= '0;
            else                                tmo_q <= tmo_q + TW'(1);
            if (state == EXEC) begin
                stat_q <= ex_stat;
                rdat_q <= ex_data;
                if (ex_write) regs[idx_q] <= data_q;
            end
            if (((state == EXEC && ex_stat != 8'h00) || timeout) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: a queue-backed RX FIFO feeds frames,
// a reference model predicts responses, TX pushes are collected and compared.
module tb_uart_cmd_controller;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] reg_out;
    logic [7:0]  err_count;
    logic        frame_ok;
    logic        busy;

    always #5 clk = ~clk;

    uart_cmd_if bus();

    uart_cmd_controller #(
        .SYNC_BYTE(8'h55), .RESP_BYTE(8'hAA), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .reg_out(reg_out), .err_count(err_count), .frame_ok(frame_ok), .busy(busy)
    );

    logic [7:0] rxq[$];
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int         act_cyc[$];
    logic [7:0] m_regs[4];
    logic [7:0] m_err;
    int total = 0, bad = 0;
    int cyc = 0, last_pop = 0, fok_cnt = 0, viol = 0;

    function automatic void rx_refresh();
        bus.rx_empty = (rxq.size() == 0);
        bus.rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endfunction

    // FIFO model and TX monitor: sample at the edge, update FIFO head just after it.
    always @(posedge clk) begin
        logic popnow;
        cyc++;
        if (rst_n) begin
            if (bus.rx_rd_en && bus.rx_empty) viol++;
            if (bus.tx_wr_en && bus.tx_full) viol++;
            if (bus.tx_wr_en) begin
                act_q.push_back(bus.tx_wr_data);
                act_cyc.push_back(cyc);
            end
            if (frame_ok) fok_cnt++;
        end
        popnow = rst_n && bus.rx_rd_en && !bus.rx_empty;
        #1;
        if (popnow) begin
            void'(rxq.pop_front());
            last_pop = cyc;
            rx_refresh();
        end
    end

    task automatic push_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        logic [7:0] st, dt;
        rxq.push_back(8'h55); rxq.push_back(c); rxq.push_back(d); rxq.push_back(k);
        if (k != 8'(c + d))        begin st = 8'h01; dt = 8'h00; end
        else if (c[7:4] == 4'h1)   begin st = 8'h00; dt = d; m_regs[c[1:0]] = d; end
        else if (c[7:4] == 4'h2)   begin st = 8'h00; dt = m_regs[c[1:0]]; end
        else                       begin st = 8'h02; dt = 8'h00; end
        if (st != 8'h00 && m_err != 8'hFF) m_err++;
        exp_q.push_back(8'hAA); exp_q.push_back(st); exp_q.push_back(dt); exp_q.push_back(8'(st + dt));
        rx_refresh();
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int k = 0;
        while (act_q.size() < n && k < 200 * n) begin
            @(negedge clk);
            k++;
        end
        ok = (act_q.size() >= n);
    endtask

    function automatic logic [31:0] m_vec();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rxq.push_back(8'h77);
        rx_refresh();
        repeat (3) @(negedge clk);
        total++; if (bus.rx_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.rx_rd_en); end
        total++; if (bus.tx_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.tx_wr_en); end
        total++; if (bus.tx_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", bus.tx_wr_data); end
        total++; if (reg_out !== 32'h0) begin bad++; $display("FAIL reset_reg_out got=%h want=0", reg_out); end
        total++; if ({err_count, frame_ok, busy} !== 10'h0) begin bad++; $display("FAIL reset_status got=%h/%b/%b want=0/0/0", err_count, frame_ok, busy); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (rxq.size() != 0 || busy !== 1'b0 || err_count !== 8'h00) begin
            bad++; $display("FAIL idle_discard got=left%0d/busy%b/err%h want=0/0/00", rxq.size(), busy, err_count);
        end
    endtask

    task automatic test_write();
        logic [7:0] e, a; bit ok; int f0 = fok_cnt;
        push_frame(8'h11, 8'hA5, 8'hB6);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL write_timeout got=%0d want=4", act_q.size()); end
        total++; if (act_cyc.size() == 0 || act_cyc[0] - last_pop != 3) begin
            bad++; $display("FAIL write_latency got=%0d want=3", (act_cyc.size() == 0) ? -1 : act_cyc[0] - last_pop);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL write_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        repeat (2) @(negedge clk);
        total++; if (reg_out[15:8] !== 8'hA5) begin bad++; $display("FAIL write_reg got=%h want=a5", reg_out[15:8]); end
        total++; if (fok_cnt - f0 != 1) begin bad++; $display("FAIL write_frame_ok got=%0d want=1", fok_cnt - f0); end
    endtask

    task automatic test_read();
        logic [7:0] e, a; bit ok;
        push_frame(8'h21, 8'h00, 8'h21);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL read_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL read_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        total++; if (reg_out !== m_vec()) begin bad++; $display("FAIL read_regs got=%h want=%h", reg_out, m_vec()); end
    endtask

    task automatic test_bad_chk();
        logic [7:0] e, a; bit ok; int f0 = fok_cnt;
        push_frame(8'h12, 8'h3C, 8'h00);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL badchk_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL badchk_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        repeat (2) @(negedge clk);
        total++; if (reg_out !== m_vec()) begin bad++; $display("FAIL badchk_regs got=%h want=%h", reg_out, m_vec()); end
        total++; if (err_count !== m_err) begin bad++; $display("FAIL badchk_err got=%h want=%h", err_count, m_err); end
        total++; if (fok_cnt != f0) begin bad++; $display("FAIL badchk_frame_ok got=%0d want=0", fok_cnt - f0); end
    endtask

    task automatic test_illegal();
        logic [7:0] e, a; bit ok;
        rxq.push_back(8'h00); rxq.push_back(8'hFF);
        push_frame(8'h30, 8'h00, 8'h30);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL illegal_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL illegal_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        repeat (2) @(negedge clk);
        total++; if (err_count !== m_err) begin bad++; $display("FAIL illegal_err got=%h want=%h", err_count, m_err); end
    endtask

    task automatic test_timeout();
        logic [7:0] e, a; bit ok; int n = 0, k = 0;
        rxq.push_back(8'h55); rxq.push_back(8'h10);
        rx_refresh();
        while (rxq.size() != 0 && k < 50) begin @(negedge clk); k++; end
        while (busy && n < 4 * TMO) begin @(negedge clk); n++; end
        if (m_err != 8'hFF) m_err++;
        total++; if (n != TMO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO); end
        total++; if (err_count !== m_err) begin bad++; $display("FAIL timeout_err got=%h want=%h", err_count, m_err); end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL timeout_no_tx got=%0d want=0", act_q.size()); end
        push_frame(8'h13, 8'h7E, 8'h91);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL after_tmo_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL after_tmo_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] e, a; bit ok;
        push_frame(8'h23, 8'h00, 8'h23);
        wait_tx(1, ok);
        bus.tx_full = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (act_q.size() != 1 || busy !== 1'b1) begin
            bad++; $display("FAIL bp_hold got=%0d/busy%b want=1/1", act_q.size(), busy);
        end
        bus.tx_full = 1'b0;
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL bp_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        total++; if (viol != 0) begin bad++; $display("FAIL bp_protocol got=%0d want=0", viol); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, a; bit ok;
        push_frame(8'h1C, 8'hC3, 8'hDF);
        push_frame(8'h20, 8'h5A, 8'h7A);
        wait_tx(8, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d want=8", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL b2b_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        total++; if (reg_out !== m_vec()) begin bad++; $display("FAIL b2b_regs got=%h want=%h", reg_out, m_vec()); end
    endtask

    task automatic test_reset_abandon();
        logic [7:0] e, a; bit ok; int k = 0;
        @(negedge clk);
        rxq.push_back(8'h55); rxq.push_back(8'h11); rxq.push_back(8'hA5);
        rx_refresh();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'h22, 8'h00, 8'h22);
        wait_tx(4, ok);
        total++; if (!ok) begin bad++; $display("FAIL abandon_frame_timeout got=%0d want=4", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL abandon_frame_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        bus.tx_full = 1'b1;
        push_frame(8'h10, 8'h11, 8'h21);
        while (rxq.size() != 0 && k < 50) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abandon_parked got=%b want=1", busy); end
        rst_n = 1'b0;
        bus.tx_full = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL abandon_resp got=%0d want=0", act_q.size()); end
        total++; if (reg_out !== 32'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL abandon_state got=%h/%b want=0/0", reg_out, busy);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e, a; bit ok;
        for (int i = 0; i < 260; i++) push_frame(8'h12, 8'(i), 8'(i + 1));
        wait_tx(1040, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=%0d want=1040", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
            total++; if (a !== e) begin bad++; $display("FAIL sat_tx got=%h want=%h", a, e); end
        end
        act_cyc.delete();
        repeat (2) @(negedge clk);
        total++; if (err_count !== 8'hFF || m_err !== 8'hFF) begin
            bad++; $display("FAIL sat_err got=%h want=ff", err_count);
        end
        total++; if (viol != 0) begin bad++; $display("FAIL protocol got=%0d want=0", viol); end
    endtask

    initial begin
        bus.tx_full = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        rx_refresh();
        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_abandon();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
